packet_fifo: RTL and testbench
==============================

PACKET_FIFO -- requirements
Module: packet_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per beat.
REQ-002 Parameter ADDR_WIDTH, default 5, depth DEPTH = 2**ADDR_WIDTH beats.
REQ-003 Parameter AF_THRESH, default DEPTH-4, almost_full threshold in beats.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 write_enable  input  1  write beat request.
REQ-007 write_data_in  input  DATA_WIDTH  write beat data.
REQ-008 write_eof  input  1  beat is last of frame.
REQ-009 write_abort  input  1  discard current frame (qualified by write_enable).
REQ-010 read_enable  input  1  read beat request.
REQ-011 read_data_out  output  DATA_WIDTH  registered read data.
REQ-012 read_valid  output  1  read_data_out valid this cycle.
REQ-013 read_eof  output  1  read_data_out is last beat of frame.
REQ-014 full, empty, almost_full  output  1 each  status flags.
REQ-015 fifo_occu_in  output  ADDR_WIDTH+1  wr_ptr - rd_ptr (includes uncommitted beats).
REQ-016 fifo_occu_out  output  ADDR_WIDTH+1  commit_ptr - rd_ptr (readable beats).
REQ-017 frame_count  output  ADDR_WIDTH+1  committed frames not fully read.
REQ-018 drop_count  output  16  frames discarded, saturating at 0xFFFF.

Function
REQ-019 Pointers wr_ptr, commit_ptr, rd_ptr SHALL be ADDR_WIDTH+1 bits, wrapping modulo 2*DEPTH; memory stores {eof, data}.
REQ-020 full SHALL equal (fifo_occu_in == DEPTH); almost_full SHALL equal (fifo_occu_in >= AF_THRESH); empty SHALL equal (rd_ptr == commit_ptr).
REQ-021 Write FSM states SHALL be IDLE, IN_FRAME, DISCARD.
REQ-022 Beat accepted when write_enable && !full && state != DISCARD; wr_ptr increments; IDLE -> IN_FRAME on non-eof beat.
REQ-023 Accepted eof beat with write_abort=0 SHALL set commit_ptr to new wr_ptr next cycle, increment frame_count, go IDLE.
REQ-024 write_enable && write_abort SHALL rewind wr_ptr to commit_ptr, increment drop_count, go IDLE; abort wins over eof and over full.
REQ-025 write_enable while full and no abort SHALL enter DISCARD (beat dropped); in DISCARD all beats dropped; on write_eof or write_abort rewind wr_ptr to commit_ptr, increment drop_count once, go IDLE.
REQ-026 Read accepted when read_enable && !empty; rd_ptr increments; read_data_out/read_eof registered, read_valid high exactly one cycle later (latency 1).
REQ-027 Accepted read of an eof beat SHALL decrement frame_count; simultaneous commit and eof read SHALL leave frame_count unchanged.
REQ-028 Uncommitted beats SHALL never be readable; a newly committed frame is readable the cycle after commit.
REQ-029 read_data_out SHALL hold its last value when read_valid is low.

Reset
REQ-030 On reset assertion, immediately: all pointers 0, FSM IDLE, frame_count 0, drop_count 0, read_data_out 0, read_valid 0, read_eof 0, hence empty=1, full=0, almost_full=0, occupancies 0.
REQ-031 Reset mid-frame SHALL discard all stored and partial data without incrementing drop_count; memory contents need not be cleared.

Structure
REQ-032 Package packet_fifo_pkg SHALL hold wr_state_t enum (IDLE, IN_FRAME, DISCARD) and DROP_CNT_W = 16.
REQ-033 Storage SHALL be sub-module packet_fifo_ram: simple dual-port, one write port, registered read port, width DATA_WIDTH+1.

Verification (DATA_WIDTH=8, ADDR_WIDTH=5)
REQ-034 Frame 0x00,0x10,0xA4,0x7B (eof on 0x7B) -> empty falls cycle after eof beat, frame_count=1; reads return same order, read_eof with 0x7B, then frame_count=0, empty=1.
REQ-035 Bytes 0x45,0x00,0x2E with abort on third -> fifo_occu_in returns 0, empty stays 1, drop_count=1, nothing readable.
REQ-036 40-byte frame into empty FIFO, no reads -> full after beat 32, beats 33-40 dropped, at eof fifo_occu_in=0, drop_count=1, empty=1.
REQ-037 Committed 20-byte frame A, then 20-byte frame B, no reads -> B overflows and is dropped; A reads back intact, frame_count 1->0, drop_count=1.
REQ-038 Read eof beat of frame 1 in same cycle frame 2 commits -> frame_count stays 1, fifo_occu_out correct.
REQ-039 Reset asserted after 10 beats of a frame with one committed frame stored -> all outputs at reset values, drop_count=0, subsequent 4-byte frame passes per REQ-034.

Source files
------------

// File: rtl/packet_fifo_pkg.sv
// Shared types and constants for the packet FIFO: write-side FSM encoding and
// drop counter width.
package packet_fifo_pkg;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DISCARD  = 2'd2
  } wr_state_t;
endpackage

// File: rtl/packet_fifo_ram.sv
// Simple dual-port storage for {eof, data} beats. The read data port is
// registered. The eof bit at the read address is also visible combinationally.
module packet_fifo_ram #(
  parameter int WIDTH      = 9,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  reof_peek_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  // The frame counter must know, when a read is accepted, whether that beat
  // closes a frame. The registered copy only appears one cycle later.
  assign reof_peek_o = mem_q[raddr_i][WIDTH-1];
  assign rdata_o     = rdata_q;
endmodule

// File: rtl/packet_fifo.sv
// Frame-aware FIFO. Beats become readable only once their frame's eof is written.
// Aborted frames and overflowing frames are rewound and counted as drops.
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic                  write_eof,
  input  logic                  write_abort,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  read_valid,
  output logic                  read_eof,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_occu_in,
  output logic [ADDR_WIDTH:0]   fifo_occu_out,
  output logic [ADDR_WIDTH:0]   frame_count,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  wr_state_t             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  rvalid_q;

  logic                  mem_we, commit, drop, rd_acc, rd_eof_peek;
  logic [DATA_WIDTH:0]   rdata;

  assign fifo_occu_in  = wr_ptr_q - rd_ptr_q;
  assign fifo_occu_out = commit_ptr_q - rd_ptr_q;
  assign full          = (fifo_occu_in == PW'(DEPTH));
  assign almost_full   = (fifo_occu_in >= PW'(AF_THRESH));
  assign empty         = (rd_ptr_q == commit_ptr_q);
  assign rd_acc        = read_enable && !empty;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    drop         = 1'b0;
    if (write_enable) begin
      if (write_abort) begin
        wr_ptr_d = commit_ptr_q;
        drop     = 1'b1;
        state_d  = IDLE;
      end else if (state_q == DISCARD || full) begin
        // An eof that arrives while full has nothing left to wait for. Drop
        // it here so the next frame is not swallowed.
        if (write_eof) begin
          wr_ptr_d = commit_ptr_q;
          drop     = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = DISCARD;
        end
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (write_eof) begin
          commit_ptr_d = wr_ptr_q + PW'(1);
          commit       = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d      = IN_FRAME;
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
    frame_cnt_d = frame_cnt_q;
    case ({commit, rd_acc && rd_eof_peek})
      2'b10:   frame_cnt_d = frame_cnt_q + PW'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - PW'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      rvalid_q     <= rd_acc;
    end
  end

  packet_fifo_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk         (clk),
    .rst         (reset),
    .we_i        (mem_we),
    .waddr_i     (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i     ({write_eof, write_data_in}),
    .re_i        (rd_acc),
    .raddr_i     (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o     (rdata),
    .reof_peek_o (rd_eof_peek)
  );

  assign read_data_out = rdata[DATA_WIDTH-1:0];
  assign read_eof      = rdata[DATA_WIDTH];
  assign read_valid    = rvalid_q;
  assign frame_count   = frame_cnt_q;
  assign drop_count    = drop_cnt_q;
endmodule

// File: tb/tb_packet_fifo.sv
// Scoreboard bench for packet_fifo: directed frame scenarios plus random traffic,
// all checked against a queue-based model of committed/pending beats.
module tb_packet_fifo;
  typedef struct packed { logic eof; logic [7:0] d; } beat_t;

  logic        clk, reset;
  logic        write_enable, write_eof, write_abort, read_enable;
  logic [7:0]  write_data_in, read_data_out;
  logic        read_valid, read_eof, full, empty, almost_full;
  logic [5:0]  fifo_occu_in, fifo_occu_out, frame_count;
  logic [15:0] drop_count;

  packet_fifo dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_data_in(write_data_in),
    .write_eof(write_eof), .write_abort(write_abort), .read_enable(read_enable),
    .read_data_out(read_data_out), .read_valid(read_valid), .read_eof(read_eof),
    .full(full), .empty(empty), .almost_full(almost_full), .fifo_occu_in(fifo_occu_in),
    .fifo_occu_out(fifo_occu_out), .frame_count(frame_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: committed beats, beats of the frame being written, reads in flight
  beat_t comm[$];
  beat_t pend[$];
  beat_t sb[$];
  bit    disc_m;
  int    drops_m, frames_m;

  int d_tot, d_pass, m_tot, m_pass;

  task automatic dchk(input string name, input int act, input int exp);
    d_tot++;
    if (act == exp) d_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    comm.delete(); pend.delete(); sb.delete();
    disc_m = 0; drops_m = 0; frames_m = 0;
  endtask

  task automatic model_drop();
    pend.delete();
    disc_m = 0;
    if (drops_m < 65535) drops_m++;
  endtask

  task automatic model_step(input bit we, input logic [7:0] d, input bit eof, input bit ab, input bit re);
    bit full_m;
    full_m = (comm.size() + pend.size()) == 32;
    if (re && comm.size() > 0) begin
      beat_t b;
      b = comm.pop_front();
      sb.push_back(b);
      if (b.eof) frames_m--;
    end
    if (we) begin
      if (ab) model_drop();
      else if (disc_m || full_m) begin
        if (eof) model_drop();
        else disc_m = 1;
      end else begin
        beat_t nb;
        nb.eof = eof; nb.d = d;
        pend.push_back(nb);
        if (eof) begin
          foreach (pend[i]) comm.push_back(pend[i]);
          pend.delete();
          frames_m++;
        end
      end
    end
  endtask

  task automatic cyc(input bit we, input logic [7:0] d, input bit eof, input bit ab, input bit re);
    write_enable = we; write_data_in = d; write_eof = eof; write_abort = ab; read_enable = re;
    @(posedge clk);
    model_step(we, d, eof, ab, re);
    #1;
  endtask

  task automatic do_reset();
    write_enable = 0; write_eof = 0; write_abort = 0; read_enable = 0; write_data_in = 8'h00;
    reset = 1'b1;
    #1;
    dchk("rst_empty", int'(empty), 1);
    dchk("rst_full", int'(full), 0);
    dchk("rst_af", int'(almost_full), 0);
    dchk("rst_occ_in", int'(fifo_occu_in), 0);
    dchk("rst_occ_out", int'(fifo_occu_out), 0);
    dchk("rst_frames", int'(frame_count), 0);
    dchk("rst_drops", int'(drop_count), 0);
    dchk("rst_rvalid", int'(read_valid), 0);
    dchk("rst_rdata", int'(read_data_out), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: read data against the scoreboard, status against the model
  logic [7:0] last_rd;
  always @(negedge clk) begin
    beat_t e;
    int occ_m;
    occ_m = comm.size() + pend.size();
    if (reset) last_rd = 8'h00;
    m_tot++;
    if (read_valid == (sb.size() != 0)) m_pass++;
    else $display("FAIL rvalid: got %0d expected %0d at %0t", read_valid, sb.size() != 0, $time);
    if (read_valid && sb.size() != 0) begin
      e = sb.pop_front();
      m_tot++;
      if ({read_eof, read_data_out} == e) m_pass++;
      else $display("FAIL rdata: got eof=%0d d=%02h expected eof=%0d d=%02h at %0t",
                    read_eof, read_data_out, e.eof, e.d, $time);
      last_rd = read_data_out;
    end else if (!read_valid) begin
      m_tot++;
      if (read_data_out == last_rd) m_pass++;
      else $display("FAIL rdata_hold: got %02h expected %02h at %0t", read_data_out, last_rd, $time);
    end
    m_tot++;
    if (fifo_occu_in == 6'(occ_m) && fifo_occu_out == 6'(comm.size()) &&
        frame_count == 6'(frames_m) && drop_count == 16'(drops_m) &&
        full == (occ_m == 32) && almost_full == (occ_m >= 28) && empty == (comm.size() == 0))
      m_pass++;
    else
      $display("FAIL status: got occ_in=%0d occ_out=%0d frames=%0d drops=%0d full=%0d af=%0d empty=%0d expected %0d %0d %0d %0d %0d %0d %0d at %0t",
               fifo_occu_in, fifo_occu_out, frame_count, drop_count, full, almost_full, empty,
               occ_m, comm.size(), frames_m, drops_m, occ_m == 32, occ_m >= 28, comm.size() == 0, $time);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic [7:0] f4 [4];
  initial begin
    f4[0] = 8'h00; f4[1] = 8'h10; f4[2] = 8'hA4; f4[3] = 8'h7B;
    model_reset();
    reset = 1'b1;
    write_enable = 0; write_eof = 0; write_abort = 0; read_enable = 0; write_data_in = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // 4-byte frame, committed then drained
    for (int i = 0; i < 4; i++) cyc(1, f4[i], i == 3, 0, 0);
    dchk("f4_empty", int'(empty), 0);
    dchk("f4_frames", int'(frame_count), 1);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 1);
    dchk("f4_frames_after", int'(frame_count), 0);
    dchk("f4_empty_after", int'(empty), 1);

    // abort on third beat
    do_reset();
    cyc(1, 8'h45, 0, 0, 0); cyc(1, 8'h00, 0, 0, 0);
    dchk("ab_empty_mid", int'(empty), 1);
    cyc(1, 8'h2E, 0, 1, 1);
    dchk("ab_occ_in", int'(fifo_occu_in), 0);
    dchk("ab_drops", int'(drop_count), 1);
    cyc(0, 8'h00, 0, 0, 1);

    // 40-byte frame overflows an empty FIFO
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(i), i == 39, 0, 0);
      if (i == 30) dchk("ovf_not_full", int'(full), 0);
      if (i == 31) dchk("ovf_full", int'(full), 1);
    end
    dchk("ovf_occ_in", int'(fifo_occu_in), 0);
    dchk("ovf_drops", int'(drop_count), 1);
    dchk("ovf_empty", int'(empty), 1);

    // frame A fits, frame B overflows; A intact
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'hA0 + i), i == 19, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), i == 19, 0, 0);
    dchk("ab2_frames", int'(frame_count), 1);
    dchk("ab2_drops", int'(drop_count), 1);
    for (int i = 0; i < 21; i++) cyc(0, 8'h00, 0, 0, 1);
    dchk("ab2_frames_after", int'(frame_count), 0);

    // eof read of frame 1 in the same cycle frame 2 commits
    do_reset();
    cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'h12, 1, 0, 0);
    cyc(1, 8'h21, 0, 0, 1); cyc(1, 8'h22, 1, 0, 1);
    dchk("sim_frames", int'(frame_count), 1);
    dchk("sim_occ_out", int'(fifo_occu_out), 2);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 1);

    // reset mid-frame with a committed frame stored
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h30 + i), i == 3, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, f4[i], i == 3, 0, 0);
    dchk("post_rst_frames", int'(frame_count), 1);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 1);
    dchk("post_rst_empty", int'(empty), 1);

    // random traffic with varying read pressure
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int rp;
      rp = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 50 : 90;
      for (int i = 0; i < 600; i++)
        cyc($urandom_range(99) < 70, 8'($urandom), $urandom_range(7) == 0,
            $urandom_range(39) == 0, $urandom_range(99) < rp);
    end
    for (int i = 0; i < 40; i++) cyc(0, 8'h00, 0, 0, 1);
    dchk("drain_occ_out", int'(fifo_occu_out), 0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", d_pass + m_pass, d_tot + m_tot);
    $finish;
  end
endmodule
